// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response queue to decode, redirect flush with stale-response drop, optional QED duplication.
// i_reset is active-low and asynchronous.
module if_fetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter bit              QED_EN          = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_redirect_valid,
    input  logic [XLEN-1:0]          i_redirect_pc,
    output logic                     o_imem_req_valid,
    input  logic                     i_imem_req_ready,
    output logic [XLEN-1:0]          o_imem_req_addr,
    input  logic                     i_imem_rsp_valid,
    input  logic [31:0]              i_imem_rsp_data,
    input  logic                     i_qed_exec_dup,
    output logic                     o_dec_valid,
    input  logic                     i_dec_ready,
    output logic [31:0]              o_dec_instr,
    output logic [XLEN-1:0]          o_dec_pc,
    output logic                     o_dec_is_dup,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = CW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] r_fetch_pc;
    logic [31:0]     r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop;
    logic            r_dup_phase;

    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [AW-1:0]   w_wr_ptr_nxt;
    logic [AW-1:0]   w_rd_ptr_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [OW-1:0]   w_outstanding_nxt;
    logic [OW-1:0]   w_drop_nxt;
    logic            w_dup_phase_nxt;

    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_wr_en;
    logic            w_dec_valid;
    logic            w_dec_fire;
    logic            w_dup_en;
    logic            w_pop;
    logic [OW-1:0]   w_live;
    logic [XLEN-1:0] w_rsp_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic [31:0]     w_head_instr;

    // Duplicate encoding: move nonzero architectural register fields into the upper half of the file.
    function automatic logic [31:0] f_remap(input logic [31:0] instr);
        logic [6:0]  opc;
        logic        has_rd;
        logic        has_rs1;
        logic        has_rs2;
        logic [31:0] res;
        opc     = instr[6:0];
        has_rd  = !(opc == OPC_STORE || opc == OPC_BRANCH);
        has_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
        has_rs2 = !(opc == OPC_OPIMM || opc == OPC_LOAD || opc == OPC_JALR ||
                    opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL ||
                    opc == OPC_SYSTEM);
        res = instr;
        if (has_rd  && (instr[11:7]  != 5'd0)) res[11] = 1'b1;
        if (has_rs1 && (instr[19:15] != 5'd0)) res[19] = 1'b1;
        if (has_rs2 && (instr[24:20] != 5'd0)) res[24] = 1'b1;
        return res;
    endfunction

    // Credit rule: queued entries plus in-flight requests never exceed DEPTH.
    assign w_req_valid = i_reset && !i_redirect_valid &&
                         (r_outstanding < OW'(MAX_OUTSTANDING)) &&
                         ((SW'(r_count) + SW'(r_outstanding)) < SW'(DEPTH));
    assign w_req_fire  = w_req_valid && i_imem_req_ready;

    // Live requests were issued sequentially up to fetch_pc-4, so the oldest one's PC is recoverable.
    assign w_live      = r_outstanding - r_drop;
    assign w_rsp_pc    = r_fetch_pc - (XLEN'(w_live) << 2);
    assign w_wr_en     = i_imem_rsp_valid && (r_drop == '0) && !i_redirect_valid;

    assign w_dec_valid = (r_count != '0);
    assign w_dec_fire  = w_dec_valid && i_dec_ready && !i_redirect_valid;
    assign w_dup_en    = QED_EN && i_qed_exec_dup;
    assign w_pop       = w_dec_fire && (r_dup_phase || !w_dup_en);

    assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);
    assign w_head_instr  = r_instr[r_rd_ptr];

    // Next-state for pointers, counters, fetch PC and duplication phase.
    always_comb begin
        w_fetch_pc_nxt    = r_fetch_pc;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_rd_ptr_nxt      = r_rd_ptr;
        w_count_nxt       = r_count;
        w_outstanding_nxt = r_outstanding;
        w_drop_nxt        = r_drop;
        w_dup_phase_nxt   = r_dup_phase;

        unique case ({w_req_fire, i_imem_rsp_valid})
            2'b10:   w_outstanding_nxt = r_outstanding + OW'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - OW'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase

        if (i_redirect_valid) begin
            w_fetch_pc_nxt  = w_redirect_pc;
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_count_nxt     = '0;
            w_drop_nxt      = w_outstanding_nxt;
            w_dup_phase_nxt = 1'b0;
        end else begin
            if (w_req_fire) begin
                w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
            end
            if (i_imem_rsp_valid && (r_drop != '0)) begin
                w_drop_nxt = r_drop - OW'(1);
            end
            if (w_wr_en) begin
                w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            end
            unique case ({w_wr_en, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
            if (w_dec_fire) begin
                w_dup_phase_nxt = !r_dup_phase && w_dup_en;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_dup_phase   <= 1'b0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
            r_dup_phase   <= w_dup_phase_nxt;
        end
    end

    // Payload storage; validity is tracked by the pointers and count alone.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_instr[r_wr_ptr] <= i_imem_rsp_data;
            r_pc[r_wr_ptr]    <= w_rsp_pc;
        end
    end

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = r_fetch_pc;
    assign o_dec_valid      = w_dec_valid;
    assign o_dec_instr      = r_dup_phase ? f_remap(w_head_instr) : w_head_instr;
    assign o_dec_pc         = r_pc[r_rd_ptr];
    assign o_dec_is_dup     = r_dup_phase;
    assign o_occupancy      = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: sequential fetch, back-pressure, redirect flush,
// QED duplicate remapping and PC wrap-around, against hand-computed expectations.
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        qed;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_is_dup;
    logic [2:0]  occ;

    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic        wr_dec_valid;
    logic [31:0] wr_dec_instr;
    logic [31:0] wr_dec_pc;
    logic        wr_dec_is_dup;
    logic [2:0]  wr_occ;

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0), .QED_EN(1'b1)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .i_qed_exec_dup(qed),
        .o_dec_valid(dec_valid), .i_dec_ready(dec_ready), .o_dec_instr(dec_instr),
        .o_dec_pc(dec_pc), .o_dec_is_dup(dec_is_dup), .o_occupancy(occ)
    );

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFFC), .QED_EN(1'b1)) u_wrap (
        .i_clk(clk), .i_reset(rst),
        .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .o_imem_req_valid(wr_req_valid), .i_imem_req_ready(1'b1), .o_imem_req_addr(wr_req_addr),
        .i_imem_rsp_valid(1'b0), .i_imem_rsp_data(32'h0),
        .i_qed_exec_dup(1'b0),
        .o_dec_valid(wr_dec_valid), .i_dec_ready(1'b1), .o_dec_instr(wr_dec_instr),
        .o_dec_pc(wr_dec_pc), .o_dec_is_dup(wr_dec_is_dup), .o_occupancy(wr_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] prog [0:15];
    int          lat;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return prog[a[5:2]];
    endfunction

    // One clock: in-order imem responder drives mid-cycle, accepted requests are recorded, then the edge.
    task automatic cycle();
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = word_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #1;
        if (req_valid && req_ready) pend.push_back('{due: cyc + lat, addr: req_addr});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_valid      = 1'b0;
        rsp_data       = 32'h0;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_is_dup", 32'(dec_is_dup), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_wrap_addr", wr_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_dec(input int budget);
        int n;
        n = 0;
        while (!dec_valid && n < budget) begin
            cycle();
            n++;
        end
        check("wait_dec_valid", 32'(dec_valid), 32'd1);
    endtask

    logic [31:0] exp_word [0:4];
    logic [31:0] exp_dup  [0:4];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        lat       = 1;
        req_ready = 1'b1;
        dec_ready = 1'b1;
        qed       = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = 32'hA000_0000 + 32'(i);

        // Sequential fetch, 1-cycle imem, decode always ready.
        do_reset();
        #1;
        check("wrap_first_valid", 32'(wr_req_valid), 32'd1);
        cycle();
        check("wrap_second_addr", wr_req_addr, 32'h0000_0000);
        check("no_bypass_valid", 32'(dec_valid), 32'd0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("seq_valid", 32'(dec_valid), 32'd1);
            check("seq_pc", dec_pc, 32'(4 * i));
            check("seq_instr", dec_instr, word_of(32'(4 * i)));
            check("seq_is_dup", 32'(dec_is_dup), 32'd0);
            cycle();
        end

        // Back-pressure: queue saturates, requests stop, nothing is lost.
        do_reset();
        dec_ready = 1'b0;
        repeat (6) cycle();
        check("sat_occ", 32'(occ), 32'd4);
        check("sat_req_valid", 32'(req_valid), 32'd0);
        check("sat_head_pc", dec_pc, 32'h0);
        dec_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("sat_pc", dec_pc, 32'(4 * i));
            check("sat_instr", dec_instr, word_of(32'(4 * i)));
        end

        // Redirect with a non-empty queue; low address bits of the target are ignored.
        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        cycle();
        redirect_valid = 1'b0;
        check("flush_occ", 32'(occ), 32'd0);
        check("flush_dec_valid", 32'(dec_valid), 32'd0);
        check("flush_req_addr", req_addr, 32'h0000_0200);
        wait_dec(20);
        check("flush_first_pc", dec_pc, 32'h0000_0200);
        dec_ready = 1'b1;

        // Redirect while two requests are in flight: both stale responses are dropped.
        do_reset();
        lat = 3;
        cycle();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        check("redir_occ", 32'(occ), 32'd0);
        check("redir_dec_valid", 32'(dec_valid), 32'd0);
        check("redir_req_addr", req_addr, 32'h0000_0100);
        wait_dec(20);
        check("redir_pc0", dec_pc, 32'h0000_0100);
        check("redir_instr0", dec_instr, word_of(32'h0000_0100));
        cycle();
        wait_dec(20);
        check("redir_pc1", dec_pc, 32'h0000_0104);

        // QED duplication: original then remapped duplicate, same PC.
        lat = 1;
        prog[0] = 32'h0020_81B3; exp_dup[0] = 32'h0128_89B3; // add x3,x1,x2
        prog[1] = 32'h0053_2223; exp_dup[1] = 32'h015B_2223; // sw x5,4(x6): rd field is immediate
        prog[2] = 32'h0000_0013; exp_dup[2] = 32'h0000_0013; // nop: x0 stays x0
        prog[3] = 32'h0051_0093; exp_dup[3] = 32'h0059_0893; // addi x1,x2,5: rs2 field is immediate
        prog[4] = 32'h1234_52B7; exp_dup[4] = 32'h1234_5AB7; // lui x5: only rd remapped
        for (int i = 0; i < 5; i++) exp_word[i] = prog[i];
        qed = 1'b1;
        do_reset();
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("qed_orig_valid", 32'(dec_valid), 32'd1);
            check("qed_orig_pc", dec_pc, 32'(4 * i));
            check("qed_orig_instr", dec_instr, exp_word[i]);
            check("qed_orig_is_dup", 32'(dec_is_dup), 32'd0);
            cycle();
            check("qed_dup_pc", dec_pc, 32'(4 * i));
            check("qed_dup_instr", dec_instr, exp_dup[i]);
            check("qed_dup_is_dup", 32'(dec_is_dup), 32'd1);
            cycle();
        end
        cycle();
        check("qed_phase_before_redir", 32'(dec_is_dup), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        cycle();
        redirect_valid = 1'b0;
        check("qed_redir_is_dup", 32'(dec_is_dup), 32'd0);
        check("qed_redir_occ", 32'(occ), 32'd0);
        qed = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
